// File: rtl/bcd_countdown_3d.sv
// -----------------------------------------------------------------------------
// bcd_countdown_3d
//   Three-digit BCD countdown timer. A load button presets the value (invalid
//   BCD digits are clamped to 9). A start/pause button runs or pauses the
//   countdown. In RUN the value decrements once every TICK_DIV clocks, with a
//   borrow rippling from digit0 to digit2. The counter stops at 000 and
//   raises o_Done.
//
// Ports:
//   i_Clk      - system clock, rising edge
//   i_Rst      - asynchronous active-high reset
//   i_Push     - raw buttons, asynchronous to i_Clk; [0]=start/pause, [1]=load
//   i_Load_Val - BCD preset {d2,d1,d0}
//   o_LED      - current BCD value {d2,d1,d0}
//   o_FND      - 7-segment codes {fnd2,fnd1,fnd0}, each [6:0]={g,f,e,d,c,b,a}
//   o_State    - IDLE=0, RUN=1, PAUSE=2, DONE=3 (registered)
//   o_Done     - high while in DONE (registered)
// -----------------------------------------------------------------------------
module bcd_countdown_3d #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [1:0]  i_Push,
  input  logic [11:0] i_Load_Val,
  output logic [11:0] o_LED,
  output logic [20:0] o_FND,
  output logic [1:0]  o_State,
  output logic        o_Done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clamp one nibble to a legal BCD digit.
  function automatic logic [3:0] f_clamp_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      f_clamp_digit = 4'd9;
    end else begin
      f_clamp_digit = d;
    end
  endfunction

  // Clamp all three digits of a preset.
  function automatic logic [11:0] f_clamp(input logic [11:0] v);
    f_clamp = {f_clamp_digit(v[11:8]), f_clamp_digit(v[7:4]), f_clamp_digit(v[3:0])};
  endfunction

  // BCD decrement by one; the caller never presents 000.
  function automatic logic [11:0] f_dec(input logic [11:0] v);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       b0;
    logic       b1;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 == 4'd0) begin
      d0 = 4'd9;
      b0 = 1'b1;
    end else begin
      d0 = d0 - 4'd1;
      b0 = 1'b0;
    end
    if (b0) begin
      if (d1 == 4'd0) begin
        d1 = 4'd9;
        b1 = 1'b1;
      end else begin
        d1 = d1 - 4'd1;
        b1 = 1'b0;
      end
    end else begin
      b1 = 1'b0;
    end
    if (b1) begin
      if (d2 == 4'd0) begin
        d2 = 4'd9;
      end else begin
        d2 = d2 - 4'd1;
      end
    end else begin
      d2 = d2;
    end
    f_dec = {d2, d1, d0};
  endfunction

  // Active-high 7-segment code {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h3F;
      4'd1:    f_seg = 7'h06;
      4'd2:    f_seg = 7'h5B;
      4'd3:    f_seg = 7'h4F;
      4'd4:    f_seg = 7'h66;
      4'd5:    f_seg = 7'h6D;
      4'd6:    f_seg = 7'h7D;
      4'd7:    f_seg = 7'h07;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_prev;
  logic [1:0]    w_edge;
  logic          w_start;
  logic          w_load;

  state_t        r_state;
  logic [11:0]   r_value;
  logic [PW-1:0] r_presc;
  logic          r_done;

  logic          w_tick;
  logic [11:0]   w_dec_val;
  logic          w_dec_zero;

  // Two-flop synchronizer plus previous-sample flop for edge detection.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= i_Push;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 & ~r_prev;
  assign w_load     = w_edge[1];
  // Load has priority, so a coincident start edge is simply dropped.
  assign w_start    = w_edge[0] & ~w_edge[1];

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_dec_val  = f_dec(r_value);
  assign w_dec_zero = (w_dec_val == 12'h000);

  // Control FSM: value, prescaler, state and done flag.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
      r_value <= 12'h000;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_IDLE;
      r_value <= f_clamp(i_Load_Val);
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (r_value != 12'h000) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // The prescaler keeps counting on the pause edge itself; the
          // paused count resumes from there.
          if (w_tick) begin
            r_presc <= '0;
            r_value <= w_dec_val;
            if (w_dec_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (w_start) begin
              r_state <= ST_PAUSE;
            end else begin
              r_state <= ST_RUN;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
            if (w_start) begin
              r_state <= ST_PAUSE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (w_start) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_LED   = r_value;
  assign o_FND   = {f_seg(r_value[11:8]), f_seg(r_value[7:4]), f_seg(r_value[3:0])};
  assign o_State = r_state;
  assign o_Done  = r_done;

endmodule

// File: tb/tb_bcd_countdown_3d.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown_3d
//   Randomized plus directed stimulus for bcd_countdown_3d (TICK_DIV=4).
//   A decimal reference model predicts the outputs after every clock edge and
//   pushes them into a scoreboard queue; a monitor on the falling edge pops
//   and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_bcd_countdown_3d;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  push;
  logic [11:0] ld;
  logic [11:0] o_LED;
  logic [20:0] o_FND;
  logic [1:0]  o_State;
  logic        o_Done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] led;
    logic [20:0] fnd;
    logic [1:0]  st;
    logic        done;
  } exp_t;

  exp_t sb[$];

  // Reference model state: value as a decimal integer 0..999.
  int          m_val;
  int          m_presc;
  int          m_state;
  int          m_done;
  logic [1:0]  h1, h2, h3;   // pin levels sampled at the last three edges

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_countdown_3d #(.TICK_DIV(TD)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Push     (push),
    .i_Load_Val (ld),
    .o_LED      (o_LED),
    .o_FND      (o_FND),
    .o_State    (o_State),
    .o_Done     (o_Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] fnd_of(input int v);
    fnd_of = {seg_tab[v / 100], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  function automatic int clamp_val(input logic [11:0] x);
    int d2, d1, d0;
    d2 = (x[11:8] > 4'd9) ? 9 : int'(x[11:8]);
    d1 = (x[7:4]  > 4'd9) ? 9 : int'(x[7:4]);
    d0 = (x[3:0]  > 4'd9) ? 9 : int'(x[3:0]);
    clamp_val = d2 * 100 + d1 * 10 + d0;
  endfunction

  task automatic model_reset();
    m_val = 0; m_presc = 0; m_state = 0; m_done = 0;
    h1 = 2'b00; h2 = 2'b00; h3 = 2'b00;
  endtask

  // One clock edge of the reference: a press acts when the pin was seen low
  // then high at the edges two and three cycles back.
  task automatic model_edge();
    logic [1:0] ev;
    int nxt;
    ev = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = push;
    if (ev[1]) begin
      m_val = clamp_val(ld); m_state = 0; m_presc = 0; m_done = 0;
    end else begin
      case (m_state)
        0: if (ev[0]) begin
             if (m_val != 0) m_state = 1;
             else begin m_state = 3; m_done = 1; end
           end
        1: begin
             nxt = ev[0] ? 2 : 1;
             if (m_presc == TD - 1) begin
               m_presc = 0;
               m_val = m_val - 1;
               if (m_val == 0) begin m_state = 3; m_done = 1; end
               else m_state = nxt;
             end else begin
               m_presc = m_presc + 1;
               m_state = nxt;
             end
           end
        2: if (ev[0]) m_state = 1;
        default: ;
      endcase
    end
  endtask

  // Apply pins for one cycle; predict the post-edge outputs.
  task automatic step(input logic [1:0] p);
    exp_t e;
    push = p;
    @(posedge clk);
    model_edge();
    e.led = to_bcd(m_val); e.fnd = fnd_of(m_val);
    e.st = 2'(m_state); e.done = (m_done != 0);
    sb.push_back(e);
    #1;
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    repeat (n) step(p);
  endtask

  task automatic press(input logic [1:0] p);
    hold(p, 3);
    hold(2'b00, 3);
  endtask

  task automatic wait_led(input logic [11:0] v, input int max_cyc);
    int n = 0;
    while (o_LED !== v && n < max_cyc) begin
      step(2'b00);
      n++;
    end
    chk("wait_led", 32'(o_LED), 32'(v));
  endtask

  // Asynchronous reset asserted between clocks; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    push = 2'b00;
    #1;
    chk("rst_led",   32'(o_LED),   32'h000);
    chk("rst_fnd",   32'(o_FND),   32'h0FDFBF);
    chk("rst_state", 32'(o_State), 32'd0);
    chk("rst_done",  32'(o_Done),  32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: every edge's prediction is checked half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_led",   32'(o_LED),   32'(e.led));
      chk("sb_fnd",   32'(o_FND),   32'(e.fnd));
      chk("sb_state", 32'(o_State), 32'(e.st));
      chk("sb_done",  32'(o_Done),  32'(e.done));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; push = 2'b00; ld = 12'h000;
    model_reset();
    #12;
    do_reset();

    // Borrow chain through 100 -> 099.
    ld = 12'h102;
    press(2'b10);
    press(2'b01);
    wait_led(12'h099, 40);
    // Hundreds digit is 0, tens and units are 9.
    chk("fnd_099", 32'(o_FND), 32'({7'h3F, 7'h6F, 7'h6F}));
    hold(2'b00, 10);

    // Terminal count and DONE stickiness.
    ld = 12'h003;
    press(2'b10);
    press(2'b01);
    wait_led(12'h000, 40);
    chk("term_state", 32'(o_State), 32'd3);
    chk("term_done",  32'(o_Done),  32'd1);
    press(2'b01);
    press(2'b01);
    chk("done_stays", 32'(o_State), 32'd3);
    ld = 12'h005;
    press(2'b10);
    chk("reload_state", 32'(o_State), 32'd0);
    chk("reload_done",  32'(o_Done),  32'd0);

    // Pause and resume.
    ld = 12'h050;
    press(2'b10);
    hold(2'b01, 3);
    wait_led(12'h049, 20);
    hold(2'b01, 3);
    hold(2'b00, 20);
    chk("pause_led",   32'(o_LED),   32'h049);
    chk("pause_state", 32'(o_State), 32'd2);
    press(2'b01);
    hold(2'b00, 12);

    // Clamp, zero start, simultaneous edges, long hold.
    ld = 12'h0AF;
    press(2'b10);
    chk("clamp", 32'(o_LED), 32'h099);
    ld = 12'h000;
    press(2'b10);
    press(2'b01);
    chk("zero_start", 32'(o_State), 32'd3);
    ld = 12'h321;
    press(2'b11);
    chk("both_state", 32'(o_State), 32'd0);
    chk("both_led",   32'(o_LED),   32'h321);
    hold(2'b01, 100);
    chk("held_state", 32'(o_State), 32'd1);
    hold(2'b00, 4);

    // Reset in the middle of a run.
    ld = 12'h050;
    press(2'b10);
    press(2'b01);
    wait_led(12'h047, 30);
    hold(2'b00, 3);
    do_reset();
    hold(2'b00, 20);
    chk("post_rst_led", 32'(o_LED), 32'h000);

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      ld = 12'($urandom);
      if (r < 3)       do_reset();
      else if (r < 25) hold(2'b10, $urandom_range(1, 6));
      else if (r < 65) hold(2'b01, $urandom_range(1, 6));
      else if (r < 70) hold(2'b11, $urandom_range(1, 6));
      else             hold(2'b00, $urandom_range(1, 12));
    end

    hold(2'b00, 4);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
